// File: rtl/rggen_register_bus_arbiter_pkg.sv
// Shared types and constants for the register bus arbiter.
package rggen_register_bus_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    BUSY = 2'b01,
    RESP = 2'b10
  } state_e;

  localparam logic [1:0] STATUS_OKAY   = 2'b00;
  localparam logic [1:0] STATUS_SLVERR = 2'b10;

  localparam int unsigned DEFAULT_TIMEOUT_CYCLES = 256;

endpackage

// File: rtl/rggen_round_robin_picker.sv
// Combinational round-robin picker: first set request after the last grant, with wrap.
module rggen_round_robin_picker #(
  parameter int unsigned N     = 2,
  parameter int unsigned IDX_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]     request,
  input  logic [IDX_W-1:0] last,
  output logic [N-1:0]     grant,
  output logic [IDX_W-1:0] index,
  output logic             found
);

  int unsigned pos;

  always_comb begin
    grant = '0;
    index = '0;
    found = 1'b0;
    pos   = 0;
    for (int unsigned k = 1; k <= N; k++) begin
      pos = (32'(last) + k) % N;
      if (!found && request[pos]) begin
        found      = 1'b1;
        grant[pos] = 1'b1;
        index      = IDX_W'(pos);
      end
    end
  end

endmodule

// File: rtl/rggen_register_bus_arbiter.sv
// Round-robin arbiter sharing one rggen register bus port between N requesters.
module rggen_register_bus_arbiter
  import rggen_register_bus_arbiter_pkg::*;
#(
  parameter int unsigned N_REQUESTERS   = 2,
  parameter int unsigned ADDRESS_WIDTH  = 8,
  parameter int unsigned BUS_WIDTH      = 32,
  parameter int unsigned TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES,
  parameter int unsigned CNT_WIDTH      = 9
) (
  input  logic                                i_clk,
  input  logic                                i_rst,
  input  logic [N_REQUESTERS-1:0]             i_req_valid,
  input  logic [2*N_REQUESTERS-1:0]           i_req_access,
  input  logic [ADDRESS_WIDTH*N_REQUESTERS-1:0] i_req_address,
  input  logic [BUS_WIDTH*N_REQUESTERS-1:0]   i_req_write_data,
  input  logic [BUS_WIDTH/8*N_REQUESTERS-1:0] i_req_strobe,
  output logic [N_REQUESTERS-1:0]             o_req_ready,
  output logic [1:0]                          o_req_status,
  output logic [BUS_WIDTH-1:0]                o_req_read_data,
  output logic                                o_register_valid,
  output logic [1:0]                          o_register_access,
  output logic [ADDRESS_WIDTH-1:0]            o_register_address,
  output logic [BUS_WIDTH-1:0]                o_register_write_data,
  output logic [BUS_WIDTH/8-1:0]              o_register_strobe,
  input  logic                                i_register_ready,
  input  logic [1:0]                          i_register_status,
  input  logic [BUS_WIDTH-1:0]                i_register_read_data,
  output logic                                o_busy,
  output logic [N_REQUESTERS-1:0]             o_grant
);

  localparam int unsigned IDX_W  = $clog2(N_REQUESTERS);
  localparam int unsigned STRB_W = BUS_WIDTH / 8;

  state_e                  state;
  logic [IDX_W-1:0]        last;
  logic [CNT_WIDTH-1:0]    watchdog;
  logic                    expire;
  logic [N_REQUESTERS-1:0] pick_grant;
  logic [IDX_W-1:0]        pick_index;
  logic                    pick_found;
  int unsigned             sel;
  logic [1:0]              sel_access;
  logic [ADDRESS_WIDTH-1:0] sel_address;
  logic [BUS_WIDTH-1:0]    sel_write_data;
  logic [STRB_W-1:0]       sel_strobe;

  rggen_round_robin_picker #(
    .N     (N_REQUESTERS),
    .IDX_W (IDX_W)
  ) u_picker (
    .request (i_req_valid),
    .last    (last),
    .grant   (pick_grant),
    .index   (pick_index),
    .found   (pick_found)
  );

  always_comb begin
    sel            = 32'(pick_index);
    sel_access     = i_req_access[sel*2 +: 2];
    sel_address    = i_req_address[sel*ADDRESS_WIDTH +: ADDRESS_WIDTH];
    sel_write_data = i_req_write_data[sel*BUS_WIDTH +: BUS_WIDTH];
    sel_strobe     = i_req_strobe[sel*STRB_W +: STRB_W];
  end

  always_comb begin
    expire = (TIMEOUT_CYCLES != 0) && (watchdog == CNT_WIDTH'(TIMEOUT_CYCLES - 1));
  end

  // Response is loaded on the BUSY->RESP edge so RESP outputs are already registered.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state                 <= IDLE;
      last                  <= IDX_W'(N_REQUESTERS - 1);
      watchdog              <= '0;
      o_req_ready           <= '0;
      o_req_status          <= STATUS_OKAY;
      o_req_read_data       <= '0;
      o_register_valid      <= 1'b0;
      o_register_access     <= '0;
      o_register_address    <= '0;
      o_register_write_data <= '0;
      o_register_strobe     <= '0;
      o_busy                <= 1'b0;
      o_grant               <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (pick_found) begin
            state                 <= BUSY;
            last                  <= pick_index;
            watchdog              <= '0;
            o_grant               <= pick_grant;
            o_busy                <= 1'b1;
            o_register_valid      <= 1'b1;
            o_register_access     <= sel_access;
            o_register_address    <= sel_address;
            o_register_write_data <= sel_write_data;
            o_register_strobe     <= sel_strobe;
          end
        end
        BUSY: begin
          if (i_register_ready || expire) begin
            state                 <= RESP;
            o_req_ready           <= o_grant;
            o_req_status          <= i_register_ready ? i_register_status : STATUS_SLVERR;
            o_req_read_data       <= i_register_ready ? i_register_read_data : '0;
            o_register_valid      <= 1'b0;
            o_register_access     <= '0;
            o_register_address    <= '0;
            o_register_write_data <= '0;
            o_register_strobe     <= '0;
          end else begin
            watchdog <= watchdog + 1'b1;
          end
        end
        RESP: begin
          state           <= IDLE;
          watchdog        <= '0;
          o_req_ready     <= '0;
          o_req_status    <= STATUS_OKAY;
          o_req_read_data <= '0;
          o_grant         <= '0;
          o_busy          <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_rggen_register_bus_arbiter.sv
// Directed bench for rggen_register_bus_arbiter with a transaction-level model.
module tb_rggen_register_bus_arbiter;

  localparam int N  = 2;
  localparam int AW = 8;
  localparam int BW = 32;
  localparam int SW = BW / 8;
  localparam int TO = 8;
  localparam int CW = 4;

  typedef struct {
    logic [1:0]    access;
    logic [AW-1:0] addr;
    logic [BW-1:0] wdata;
    logic [SW-1:0] strb;
  } req_t;

  typedef struct {
    int            cyc;
    logic [N-1:0]  ready;
    logic [1:0]    status;
    logic [BW-1:0] data;
    int            vc;
  } pulse_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [N-1:0]    req_valid = '0;
  logic [2*N-1:0]  req_access = '0;
  logic [AW*N-1:0] req_address = '0;
  logic [BW*N-1:0] req_write_data = '0;
  logic [SW*N-1:0] req_strobe = '0;
  logic [N-1:0]    req_ready;
  logic [1:0]      req_status;
  logic [BW-1:0]   req_read_data;
  logic            reg_valid;
  logic [1:0]      reg_access;
  logic [AW-1:0]   reg_address;
  logic [BW-1:0]   reg_write_data;
  logic [SW-1:0]   reg_strobe;
  logic            reg_ready = 1'b0;
  logic [1:0]      rsp_status = 2'b00;
  logic [BW-1:0]   rsp_data = '0;
  logic            busy;
  logic [N-1:0]    grant;

  int n_vec = 0;
  int n_bad = 0;
  int cyc = 0;
  int rsp_wait = 0;   // ready in BUSY cycle number rsp_wait (0-based); -1 = never
  int bcnt = 0;
  int vcnt = 0;
  bit served[N];
  req_t rq0[$];
  req_t rq1[$];
  pulse_t plog[$];

  always #5 clk = ~clk;

  rggen_register_bus_arbiter #(
    .N_REQUESTERS   (N),
    .ADDRESS_WIDTH  (AW),
    .BUS_WIDTH      (BW),
    .TIMEOUT_CYCLES (TO),
    .CNT_WIDTH      (CW)
  ) dut (
    .i_clk                 (clk),
    .i_rst                 (rst),
    .i_req_valid           (req_valid),
    .i_req_access          (req_access),
    .i_req_address         (req_address),
    .i_req_write_data      (req_write_data),
    .i_req_strobe          (req_strobe),
    .o_req_ready           (req_ready),
    .o_req_status          (req_status),
    .o_req_read_data       (req_read_data),
    .o_register_valid      (reg_valid),
    .o_register_access     (reg_access),
    .o_register_address    (reg_address),
    .o_register_write_data (reg_write_data),
    .o_register_strobe     (reg_strobe),
    .i_register_ready      (reg_ready),
    .i_register_status     (rsp_status),
    .i_register_read_data  (rsp_data),
    .o_busy                (busy),
    .o_grant               (grant)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s at cycle %0d: got 0x%0h, required 0x%0h", name, cyc, act, exp);
    end
  endtask

  task automatic drive_port(input int i, input bit v, input req_t r);
    req_valid[i]              = v;
    req_access[i*2 +: 2]      = v ? r.access : 2'b00;
    req_address[i*AW +: AW]   = v ? r.addr : '0;
    req_write_data[i*BW +: BW] = v ? r.wdata : '0;
    req_strobe[i*SW +: SW]    = v ? r.strb : '0;
  endtask

  always @(posedge clk) cyc++;

  // Requesters and register-block responder, driven just after the active edge.
  always @(posedge clk) begin
    req_t empty;
    empty = '{access: 2'b00, addr: '0, wdata: '0, strb: '0};
    #1;
    if (served[0]) begin
      if (rq0.size() > 0) void'(rq0.pop_front());
      served[0] = 1'b0;
    end
    if (served[1]) begin
      if (rq1.size() > 0) void'(rq1.pop_front());
      served[1] = 1'b0;
    end
    drive_port(0, rq0.size() > 0, (rq0.size() > 0) ? rq0[0] : empty);
    drive_port(1, rq1.size() > 0, (rq1.size() > 0) ? rq1[0] : empty);
    if (reg_valid) begin
      reg_ready = (rsp_wait >= 0) && (bcnt == rsp_wait);
      bcnt++;
    end else begin
      reg_ready = 1'b0;
      bcnt = 0;
    end
  end

  // Transaction-level model: a transaction picked in cycle c occupies the bus from
  // c+1 through its end cycle, and pulses the winner's ready in end+1.
  bit            model_on = 1'b0;
  bit            m_act = 1'b0;
  int            m_last = N - 1;
  int            m_win = 0;
  int            m_start = 0;
  int            m_end = -1;
  logic [1:0]    m_access;
  logic [AW-1:0] m_addr;
  logic [BW-1:0] m_wdata;
  logic [SW-1:0] m_strb;
  logic [1:0]    m_status;
  logic [BW-1:0] m_data;

  always @(negedge clk) begin
    bit busy_ph;
    bit resp_ph;
    logic [N-1:0] win_vec;
    busy_ph = m_act && (cyc >= m_start) && (m_end < 0 || cyc <= m_end);
    resp_ph = m_act && (m_end >= 0) && (cyc == m_end + 1);
    win_vec = '0;
    win_vec[m_win] = 1'b1;

    if (model_on) begin
      check("register_valid", 64'(reg_valid), 64'(busy_ph));
      check("busy", 64'(busy), 64'(busy_ph || resp_ph));
      check("grant", 64'(grant), (busy_ph || resp_ph) ? 64'(win_vec) : 64'd0);
      check("req_ready", 64'(req_ready), resp_ph ? 64'(win_vec) : 64'd0);
      check("req_status", 64'(req_status), resp_ph ? 64'(m_status) : 64'd0);
      check("req_read_data", 64'(req_read_data), resp_ph ? 64'(m_data) : 64'd0);
      if (busy_ph) begin
        check("register_access", 64'(reg_access), 64'(m_access));
        check("register_address", 64'(reg_address), 64'(m_addr));
        check("register_write_data", 64'(reg_write_data), 64'(m_wdata));
        check("register_strobe", 64'(reg_strobe), 64'(m_strb));
      end
    end

    if (rst) begin
      m_act    = 1'b0;
      m_last   = N - 1;
      model_on = 1'b1;
    end else if (model_on) begin
      if (busy_ph && m_end < 0) begin
        if (reg_ready) begin
          m_end    = cyc;
          m_status = rsp_status;
          m_data   = rsp_data;
        end else if (TO != 0 && cyc - m_start == TO - 1) begin
          m_end    = cyc;
          m_status = 2'b10;
          m_data   = '0;
        end
      end else if (resp_ph) begin
        m_act = 1'b0;
      end else if (!m_act && req_valid != '0) begin
        m_win = -1;
        for (int k = 1; k <= N; k++) begin
          int p;
          p = (m_last + k) % N;
          if (m_win < 0 && req_valid[p]) m_win = p;
        end
        m_act    = 1'b1;
        m_start  = cyc + 1;
        m_end    = -1;
        m_last   = m_win;
        m_access = req_access[m_win*2 +: 2];
        m_addr   = req_address[m_win*AW +: AW];
        m_wdata  = req_write_data[m_win*BW +: BW];
        m_strb   = req_strobe[m_win*SW +: SW];
      end
    end

    if (rst) begin
      vcnt = 0;
    end else begin
      if (reg_valid) vcnt++;
      if (req_ready != '0) begin
        plog.push_back('{cyc: cyc, ready: req_ready, status: req_status,
                         data: req_read_data, vc: vcnt});
        vcnt = 0;
        for (int i = 0; i < N; i++) if (req_ready[i]) served[i] = 1'b1;
      end
    end
  end

  task automatic check_all_zero(input string name);
    check({name, "_valid"}, 64'(reg_valid), 64'd0);
    check({name, "_busy"}, 64'(busy), 64'd0);
    check({name, "_grant"}, 64'(grant), 64'd0);
    check({name, "_ready"}, 64'(req_ready), 64'd0);
    check({name, "_status"}, 64'(req_status), 64'd0);
    check({name, "_rdata"}, 64'(req_read_data), 64'd0);
    check({name, "_addr"}, 64'(reg_address), 64'd0);
    check({name, "_wdata"}, 64'(reg_write_data), 64'd0);
    check({name, "_access"}, 64'(reg_access), 64'd0);
    check({name, "_strobe"}, 64'(reg_strobe), 64'd0);
  endtask

  task automatic do_reset(input int n);
    @(posedge clk);
    #1 rst = 1'b1;
    repeat (n) @(posedge clk);
    #1;
    check_all_zero("reset");
    rst = 1'b0;
  endtask

  task automatic wait_pulses(input string name, input int target, input int limit);
    for (int t = 0; t < limit && plog.size() < target; t++) @(posedge clk);
    check({name, "_completed"}, 64'(plog.size() >= target), 64'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "global timeout");
  end

  initial begin
    bit ok;
    int rst_cyc;
    served[0] = 1'b0;
    served[1] = 1'b0;

    do_reset(3);

    // Single write from requester 0, ready in the third BUSY cycle.
    plog.delete();
    rsp_wait = 2; rsp_status = 2'b00; rsp_data = 32'h0;
    rq0.push_back('{access: 2'b01, addr: 8'h10, wdata: 32'hDEADBEEF, strb: 4'hF});
    wait_pulses("write", 1, 50);
    repeat (4) @(posedge clk);
    check("write_pulse_count", 64'(plog.size()), 64'd1);
    if (plog.size() >= 1) begin
      check("write_ready", 64'(plog[0].ready), 64'h1);
      check("write_status", 64'(plog[0].status), 64'h0);
      check("write_busy_cycles", 64'(plog[0].vc), 64'd3);
    end

    // Both requesters continuously valid: strict alternation starting at 0.
    do_reset(1);
    plog.delete();
    rsp_wait = 1;
    for (int i = 0; i < 3; i++) begin
      rq0.push_back('{access: 2'b01, addr: 8'(8'h40 + i), wdata: 32'(32'h1000 + i), strb: 4'h3});
      rq1.push_back('{access: 2'b00, addr: 8'(8'h80 + i), wdata: 32'h0, strb: 4'hC});
    end
    wait_pulses("rr", 6, 100);
    if (plog.size() >= 6) begin
      for (int i = 0; i < 6; i++)
        check("rr_order", 64'(plog[i].ready), (i % 2 == 0) ? 64'h1 : 64'h2);
      for (int i = 1; i < 6; i++)
        check("rr_spacing", 64'(plog[i].cyc - plog[i-1].cyc), 64'd4);
    end
    repeat (3) @(posedge clk);

    // Read from requester 1 never acknowledged: watchdog returns SLVERR with zero data.
    plog.delete();
    rsp_wait = -1; rsp_status = 2'b00; rsp_data = 32'hFFFF0000;
    rq1.push_back('{access: 2'b00, addr: 8'h20, wdata: 32'h0, strb: 4'hF});
    wait_pulses("timeout", 1, 40);
    if (plog.size() >= 1) begin
      check("timeout_ready", 64'(plog[0].ready), 64'h2);
      check("timeout_status", 64'(plog[0].status), 64'h2);
      check("timeout_data", 64'(plog[0].data), 64'h0);
      check("timeout_busy_cycles", 64'(plog[0].vc), 64'd8);
    end
    rsp_wait = 0; rsp_data = 32'h55AA1234;
    rq0.push_back('{access: 2'b00, addr: 8'h24, wdata: 32'h0, strb: 4'hF});
    wait_pulses("after_timeout", 2, 40);
    if (plog.size() >= 2) begin
      check("after_timeout_ready", 64'(plog[1].ready), 64'h1);
      check("after_timeout_status", 64'(plog[1].status), 64'h0);
      check("after_timeout_data", 64'(plog[1].data), 64'h55AA1234);
    end

    // Ready in the very cycle the watchdog would expire: real response wins.
    plog.delete();
    rsp_wait = TO - 1; rsp_status = 2'b00; rsp_data = 32'h1234;
    rq0.push_back('{access: 2'b00, addr: 8'h30, wdata: 32'h0, strb: 4'hF});
    wait_pulses("expiry_race", 1, 40);
    if (plog.size() >= 1) begin
      check("expiry_race_status", 64'(plog[0].status), 64'h0);
      check("expiry_race_data", 64'(plog[0].data), 64'h1234);
      check("expiry_race_busy_cycles", 64'(plog[0].vc), 64'd8);
    end
    repeat (3) @(posedge clk);

    // Reset in the middle of BUSY: silent abort, pointer back to requester 0.
    plog.delete();
    rsp_wait = -1;
    rq0.push_back('{access: 2'b01, addr: 8'h50, wdata: 32'hCAFEF00D, strb: 4'hF});
    for (int t = 0; t < 20 && vcnt < 1; t++) @(posedge clk);
    rq1.push_back('{access: 2'b01, addr: 8'h60, wdata: 32'h0BADBEEF, strb: 4'h1});
    for (int t = 0; t < 20 && vcnt < 2; t++) @(posedge clk);
    ok = (vcnt >= 2);
    check("midbusy_reached", 64'(ok), 64'd1);
    #1 rst = 1'b1;
    @(posedge clk);
    #1;
    check_all_zero("midbusy_reset");
    rst_cyc = cyc;
    rst = 1'b0;
    rsp_wait = 0; rsp_status = 2'b00; rsp_data = 32'h0;
    wait_pulses("post_reset", 2, 40);
    if (plog.size() >= 2) begin
      check("post_reset_first_winner", 64'(plog[0].ready), 64'h1);
      check("post_reset_no_abort_pulse", 64'(plog[0].cyc >= rst_cyc + 2), 64'd1);
      check("post_reset_second_winner", 64'(plog[1].ready), 64'h2);
    end
    repeat (3) @(posedge clk);

    // Error status and data pass through to requester 1 only.
    plog.delete();
    rsp_wait = 0; rsp_status = 2'b10; rsp_data = 32'hA5A5A5A5;
    rq1.push_back('{access: 2'b00, addr: 8'h70, wdata: 32'h0, strb: 4'hF});
    wait_pulses("slverr_pass", 1, 40);
    if (plog.size() >= 1) begin
      check("slverr_pass_ready", 64'(plog[0].ready), 64'h2);
      check("slverr_pass_status", 64'(plog[0].status), 64'h2);
      check("slverr_pass_data", 64'(plog[0].data), 64'hA5A5A5A5);
    end
    repeat (5) @(posedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
